// File: rtl/split_assign_loader.sv
// Deserialises 32-bit words into one packed candidate assignment, holds it for the
// split checkers, then reports the AND of their verdicts over a valid/ready port.
module split_assign_loader #(
    parameter int ASSIGN_W   = 551,
    parameter int WORD_W     = 32,
    parameter int NWORDS     = (ASSIGN_W + WORD_W - 1) / WORD_W,
    parameter int NUM_SPLITS = 8,
    parameter int EVAL_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_last,
    output logic [ASSIGN_W-1:0]   assign_vec,
    output logic                  assign_valid,
    input  logic [NUM_SPLITS-1:0] split_x,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_sat,
    output logic [CNT_W-1:0]      res_idx,
    output logic [CNT_W-1:0]      sat_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam int PTR_W   = $clog2(NWORDS);
    localparam int LAST_LO = (NWORDS - 1) * WORD_W;
    localparam int LAST_W  = ASSIGN_W - LAST_LO;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NWORDS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [3:0]       WAIT_LAST = 4'(EVAL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_EVAL   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    logic [1:0]          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [3:0]          r_wait;
    logic [ASSIGN_W-1:0] r_shadow;
    logic [ASSIGN_W-1:0] r_assign_vec;
    logic                r_res_sat;
    logic [CNT_W-1:0]    r_res_idx;
    logic [CNT_W-1:0]    r_sat_count;
    logic [CNT_W-1:0]    r_err_count;

    logic                w_xfer;
    logic [ASSIGN_W-1:0] w_shadow_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign s_ready      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign assign_valid = (r_state == ST_EVAL);
    assign res_valid    = (r_state == ST_REPORT);
    assign w_xfer       = s_valid && s_ready;

    assign assign_vec = r_assign_vec;
    assign res_sat    = r_res_sat;
    assign res_idx    = r_res_idx;
    assign sat_count  = r_sat_count;
    assign err_count  = r_err_count;

    // Shadow with the current word merged at the pointer; the last word is truncated.
    // NOTE: default first so every path assigns w_shadow_next and no latch is inferred.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int k = 0; k < NWORDS - 1; k++) begin
            if (r_ptr == PTR_W'(k)) w_shadow_next[k*WORD_W +: WORD_W] = s_data;
        end
        if (r_ptr == LAST_PTR) w_shadow_next[ASSIGN_W-1:LAST_LO] = s_data[LAST_W-1:0];
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_ptr        <= '0;
            r_wait       <= '0;
            r_shadow     <= '0;
            r_assign_vec <= '0;
            r_res_sat    <= 1'b0;
            r_res_idx    <= '0;
            r_sat_count  <= '0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (r_ptr == LAST_PTR) begin
                            r_ptr <= '0;
                            if (s_last) begin
                                r_shadow     <= w_shadow_next;
                                r_assign_vec <= w_shadow_next;
                                r_wait       <= '0;
                                r_state      <= ST_EVAL;
                            end else begin
                                r_err_count <= sat_inc(r_err_count);
                                r_state     <= ST_DRAIN;
                            end
                        end else if (s_last) begin
                            // Short frame: abandon it without committing this word.
                            r_err_count <= sat_inc(r_err_count);
                            r_ptr       <= '0;
                        end else begin
                            r_shadow <= w_shadow_next;
                            r_ptr    <= r_ptr + PTR_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer && s_last) begin
                        r_ptr   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_EVAL: begin
                    if (r_wait == WAIT_LAST) begin
                        r_res_sat <= &split_x;
                        r_state   <= ST_REPORT;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                default: begin
                    if (res_ready) begin
                        r_res_idx <= r_res_idx + CNT_ONE;
                        if (r_res_sat) r_sat_count <= sat_inc(r_sat_count);
                        r_state <= ST_LOAD;
                    end
                end
            endcase
        end
    end

endmodule
